// File: rtl/kuznechik_pkg.sv
// Kuznechik (GOST R 34.12-2015) constants, FSM encoding, GF(2^8) multiply and S-box helpers.
// The inverse S-box is elaborated only when KUZNECHIK_DECRYPT_EN is defined.
package kuznechik_pkg;

    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NBYTES     = BLOCK_W / BYTE_W;
    localparam int unsigned ROUNDS     = 10;
    localparam int unsigned KEY_ADDR_W = 4;
    localparam logic [7:0]  GF_POLY    = 8'hC3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_S,
        ST_L,
        ST_DONE
    } state_t;

    // L coefficients, element [15] applies to the most significant byte
    localparam logic [NBYTES-1:0][7:0] L_COEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    localparam int unsigned PI_TAB [256] = '{
        252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
        233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
        249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
          5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
        235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
        181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
         21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
         50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
        223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
        224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
        167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
        173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
          7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
        225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
         32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
         89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] w);
        logic [BLOCK_W-1:0] t;
        logic [BLOCK_W-1:0] r;
        t = w;
        r = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            r = {r[BLOCK_W-BYTE_W-1:0], 8'(PI_TAB[t[BLOCK_W-1 -: BYTE_W]])};
            t = t << BYTE_W;
        end
        return r;
    endfunction

`ifdef KUZNECHIK_DECRYPT_EN
    typedef logic [255:0][7:0] sbox_t;

    function automatic sbox_t build_pi_inv();
        sbox_t t;
        t = '0;
        for (int unsigned i = 0; i < 256; i++) t[8'(PI_TAB[i])] = 8'(i);
        return t;
    endfunction

    localparam sbox_t PI_INV = build_pi_inv();

    function automatic logic [BLOCK_W-1:0] sub_bytes_inv(input logic [BLOCK_W-1:0] w);
        logic [BLOCK_W-1:0] t;
        logic [BLOCK_W-1:0] r;
        t = w;
        r = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            r = {r[BLOCK_W-BYTE_W-1:0], PI_INV[t[BLOCK_W-1 -: BYTE_W]]};
            t = t << BYTE_W;
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/kuznechik_l_step.sv
// One combinational Kuznechik R step; with KUZNECHIK_DECRYPT_EN it can also perform the inverse step.
module kuznechik_l_step
    import kuznechik_pkg::*;
(
`ifdef KUZNECHIK_DECRYPT_EN
    input  logic               inverse,
`endif
    input  logic [BLOCK_W-1:0] src,
    output logic [BLOCK_W-1:0] dst
);

    // Linear form over the 16 bytes, MSB byte weighted by the first coefficient
    function automatic logic [BYTE_W-1:0] l_lin(input logic [BLOCK_W-1:0] w);
        logic [BLOCK_W-1:0] t;
        logic [BLOCK_W-1:0] c;
        logic [BYTE_W-1:0]  acc;
        t   = w;
        c   = L_COEF;
        acc = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            acc = acc ^ gf_mul(t[BLOCK_W-1 -: BYTE_W], c[BLOCK_W-1 -: BYTE_W]);
            t   = t << BYTE_W;
            c   = c << BYTE_W;
        end
        return acc;
    endfunction

    logic [BLOCK_W-1:0] fwd;

    assign fwd = {l_lin(src), src[BLOCK_W-1:BYTE_W]};

`ifdef KUZNECHIK_DECRYPT_EN
    logic [BLOCK_W-1:0] rot;

    // Inverse step weights (a14..a0, a15): rotate the top byte to the bottom first
    assign rot = {src[BLOCK_W-BYTE_W-1:0], src[BLOCK_W-1 -: BYTE_W]};
    assign dst = inverse ? {src[BLOCK_W-BYTE_W-1:0], l_lin(rot)} : fwd;
`else
    assign dst = fwd;
`endif

endmodule

// File: rtl/kuznechik_cipher_par.sv
// Kuznechik block cipher with run-time round keys and an L_STEPS-way unrolled L transform.
// Define KUZNECHIK_DECRYPT_EN to add the decrypt_i port and the inverse datapath.
module kuznechik_cipher_par
    import kuznechik_pkg::*;
#(
    parameter int unsigned L_STEPS = 1,
    parameter int unsigned DATA_W  = 128
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  request_i,
    input  logic                  ack_i,
    input  logic [DATA_W-1:0]     data_i,
`ifdef KUZNECHIK_DECRYPT_EN
    input  logic                  decrypt_i,
`endif
    input  logic                  key_we_i,
    input  logic [KEY_ADDR_W-1:0] key_addr_i,
    input  logic [DATA_W-1:0]     key_data_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     data_o
);

    localparam int unsigned L_CYCLES = NBYTES / L_STEPS;
    localparam int unsigned LCNT_W   = 4;
    localparam int unsigned RND_W    = KEY_ADDR_W;
    localparam logic [LCNT_W-1:0] L_LAST     = LCNT_W'(L_CYCLES - 1);
    localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(ROUNDS - 1);

    if (!((L_STEPS == 1) || (L_STEPS == 2) || (L_STEPS == 4) || (L_STEPS == 8) ||
          (L_STEPS == 16)) || (DATA_W != BLOCK_W)) begin : g_bad_cfg
        $fatal(1, "kuznechik_cipher_par: L_STEPS must be 1/2/4/8/16 and DATA_W must be 128");
    end

    state_t              state_q, state_n;
    logic [RND_W-1:0]    round_q, round_n;
    logic [LCNT_W-1:0]   l_cnt_q, l_cnt_n;
    logic [DATA_W-1:0]   work_q, work_n;
    logic                busy_n, valid_n;
    logic [DATA_W-1:0]   data_n;
    logic                is_dec;
    logic                accept;
    logic [DATA_W-1:0]   key_mem [ROUNDS];
    logic [DATA_W-1:0]   round_key, s_out, l_out;

`ifdef KUZNECHIK_DECRYPT_EN
    logic dec_q, dec_n;
    assign is_dec = dec_q;
    assign s_out  = dec_q ? sub_bytes_inv(work_q) : sub_bytes(work_q);
`else
    assign is_dec = 1'b0;
    assign s_out  = sub_bytes(work_q);
`endif

    // Decryption walks the key schedule backwards
    assign round_key = key_mem[is_dec ? (LAST_ROUND - round_q) : round_q];

    for (genvar k = 0; k < L_STEPS; k++) begin : g_step
        logic [DATA_W-1:0] stage_in, stage_out;
        if (k == 0) begin : g_first
            assign stage_in = work_q;
        end else begin : g_next
            assign stage_in = g_step[k-1].stage_out;
        end
        kuznechik_l_step u_l_step (
`ifdef KUZNECHIK_DECRYPT_EN
            .inverse (dec_q),
`endif
            .src     (stage_in),
            .dst     (stage_out)
        );
    end
    assign l_out = g_step[L_STEPS-1].stage_out;

    // Keys are frozen while a block is in flight
    always_ff @(posedge clk_i) begin
        if (key_we_i && !busy_o && (key_addr_i < KEY_ADDR_W'(ROUNDS)))
            key_mem[key_addr_i] <= key_data_i;
    end

    always_comb begin
        state_n = state_q;
        round_n = round_q;
        l_cnt_n = l_cnt_q;
        work_n  = work_q;
        busy_n  = busy_o;
        valid_n = valid_o;
        data_n  = data_o;
        accept  = 1'b0;
`ifdef KUZNECHIK_DECRYPT_EN
        dec_n   = dec_q;
`endif
        unique case (state_q)
            ST_IDLE: accept = request_i;
            ST_KEY: begin
                work_n  = work_q ^ round_key;
                round_n = round_q + RND_W'(1);
                l_cnt_n = '0;
                if (round_q == LAST_ROUND) begin
                    data_n  = work_q ^ round_key;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_DONE;
                end else begin
                    state_n = is_dec ? ST_L : ST_S;
                end
            end
            ST_S: begin
                work_n  = s_out;
                l_cnt_n = '0;
                state_n = is_dec ? ST_KEY : ST_L;
            end
            ST_L: begin
                work_n = l_out;
                if (l_cnt_q == L_LAST) begin
                    l_cnt_n = '0;
                    state_n = is_dec ? ST_S : ST_KEY;
                end else begin
                    l_cnt_n = l_cnt_q + LCNT_W'(1);
                end
            end
            ST_DONE: begin
                if (ack_i) begin
                    valid_n = 1'b0;
                    state_n = ST_IDLE;
                    accept  = request_i;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (accept) begin
            work_n  = data_i;
            round_n = '0;
            l_cnt_n = '0;
            busy_n  = 1'b1;
            state_n = ST_KEY;
`ifdef KUZNECHIK_DECRYPT_EN
            dec_n   = decrypt_i;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            l_cnt_q <= '0;
            work_q  <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
`ifdef KUZNECHIK_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            round_q <= round_n;
            l_cnt_q <= l_cnt_n;
            work_q  <= work_n;
            busy_o  <= busy_n;
            valid_o <= valid_n;
            data_o  <= data_n;
`ifdef KUZNECHIK_DECRYPT_EN
            dec_q   <= dec_n;
`endif
        end
    end

endmodule
